avalon_st_pkt_arbiter_10gb: RTL and testbench
=============================================

Name: avalon_st_pkt_arbiter_10gb

Overview:
- Packet-atomic round-robin arbiter sharing one 64-bit Avalon-ST 10GbMAC-style stream (data/valid/ready/sop/eop/empty[2:0]/error[5:0]) between NPORTS sources, e.g. several pcap replayers feeding one MAC or pcap writer.
- Once a source is granted, its whole packet passes uninterrupted, then an inter-packet gap of IPG idle cycles is enforced.
- Also discards stray mid-packet beats and counts packets and drops.

Parameters:
- NPORTS, 2, number of requesting sources (2..4).
- IPG, 4, idle cycles forced after each eop beat (0..255).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- pause  in  1  when 1, no new grant is issued; a packet already in progress completes.
- in_data  in  NPORTS*64  per-port data; port p occupies [p*64+:64].
- in_valid  in  NPORTS  per-port valid.
- in_ready  out  NPORTS  per-port ready (ready latency 0).
- in_sop  in  NPORTS  per-port start of packet.
- in_eop  in  NPORTS  per-port end of packet.
- in_empty  in  NPORTS*3  per-port empty byte count, [p*3+:3].
- in_error  in  NPORTS*6  per-port error, [p*6+:6].
- out_data  out  64  muxed data.
- out_valid  out  1  muxed valid.
- out_ready  in  1  sink ready (ready latency 0).
- out_sop  out  1  muxed start of packet.
- out_eop  out  1  muxed end of packet.
- out_empty  out  3  muxed empty.
- out_error  out  6  muxed error.
- grant  out  NPORTS  one-hot current owner; 0 when not in SEND.
- busy  out  1  1 in SEND or GAP.
- pkt_count  out  16  packets forwarded (eop transfers); wraps.
- drop_count  out  16  stray beats discarded; saturates at 0xFFFF.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, grant=0, last=NPORTS-1, gap counter=0, counters=0. All outputs 0 immediately, including out_valid and in_ready. A packet cut by reset is not resumed; its remaining beats are treated as stray.
- Transfer rule: a beat transfers on a cycle with valid=1 and ready=1.
- IDLE:
  - Eligible ports: in_valid[p]=1 and in_sop[p]=1. If pause=0 and any port is eligible, choose the first eligible port searching from last+1 modulo NPORTS. Register it into grant and last; next state is SEND.
  - Arbitration costs one cycle: no beat is forwarded in the IDLE cycle, out_valid=0.
  - Stray beats: any port with in_valid=1 and in_sop=0 gets in_ready=1 (also while pause=1). The beat is discarded and drop_count increments by 1 per cycle, regardless of how many ports drop in that cycle.
  - Eligible ports see in_ready=0 in IDLE.
- SEND, owner g:
  - Zero-latency combinational pass-through: out_*=in_*[g], out_valid=in_valid[g], in_ready[g]=out_ready. All other in_ready bits are 0.
  - sop/error/empty are passed unmodified; a second sop inside a packet is not checked.
  - On a transfer with eop=1: pkt_count increments; grant clears next cycle; next state is GAP if IPG>0, else IDLE.
  - A single-beat packet (sop=eop=1) is legal.
  - pause has no effect in SEND.
- GAP: counter loads IPG-1 on entry and decrements each cycle. When it reads 0, next state is IDLE. out_valid=0, all in_ready=0 (no drops).
- Packet-to-packet spacing: eop beat in cycle t, next sop earliest in cycle t+IPG+2 (IPG gap cycles plus the arbitration cycle).
- While out_ready=0 in SEND, outputs simply track the owner's inputs; the owner is held.
- last is updated only at grant time, so each port is granted at most once per NPORTS grants while all ports request continuously.

Decomposition:
- Shared package avalon_st_10gb_pkg: beat field widths (DATA_W=64, EMPTY_W=3, ERROR_W=6) and the state encoding (IDLE, SEND, GAP).
- One sub-module, rr_pick: combinational round-robin first-eligible picker. Inputs: eligible vector and last; output: one-hot selection. Parameterised on NPORTS.

Test Plan:
- Single source, IPG=4: port0 sends a 3-beat packet with out_ready=1 -> out beats in cycles 1..3 after arbitration, eop in the 3rd; a second packet's sop appears no earlier than 6 cycles after the eop; pkt_count=2.
- Two sources both continuously offering 2-beat packets -> grant sequence 0,1,0,1; no beat interleaving between packets; pkt_count=4 after 4 packets.
- Backpressure: out_ready toggled 1,0,1,0 during a 4-beat packet on port1 -> in_ready[1] mirrors out_ready, each beat appears exactly once, in_ready[0]=0 throughout.
- Stray beat: port0 presents valid=1, sop=0 for 2 cycles in IDLE -> in_ready[0]=1, out_valid=0, drop_count=2.
- pause=1 with port1 requesting -> no grant; deassert pause -> grant=0b10 next cycle. Asserting pause mid-packet -> that packet still completes.
- reset_n pulled low mid-packet -> out_valid, grant and counters read 0 immediately. After release, the remaining non-sop beats are dropped, drop_count increments by 1 per dropped beat, and the next sop is granted normally.

Source files
------------

// File: rtl/avalon_st_10gb_pkg.sv
// Beat field widths and arbiter state encoding shared by the 10GbE Avalon-ST stream blocks.
// Pure declarations: no logic, no latency, no flow control.
package avalon_st_10gb_pkg;

    localparam int DATA_W  = 64;
    localparam int EMPTY_W = 3;
    localparam int ERROR_W = 6;
    localparam int CNT_W   = 16;
    localparam int GAP_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin first-eligible picker: searches from last+1 modulo NPORTS, returns one-hot.
// Purely combinational, zero latency; no flow control of its own.
module rr_pick #(
    parameter int NPORTS = 2,
    parameter int IDX_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic [NPORTS-1:0] eligible,
    input  logic [IDX_W-1:0]  last,
    output logic [NPORTS-1:0] sel
);

    logic found;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        // Offset 1..NPORTS so the previous owner is considered last.
        for (int i = 1; i <= NPORTS; i++) begin
            for (int p = 0; p < NPORTS; p++) begin
                if (!found && eligible[p] && (p == ((int'(last) + i) % NPORTS))) begin
                    sel[p] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/avalon_st_pkt_arbiter_10gb.sv
// Packet-atomic round-robin arbiter muxing NPORTS Avalon-ST sources onto one 64-bit stream.
// Latency: one arbitration cycle per packet, then zero-latency pass-through; IPG idle cycles after eop.
// Backpressure: out_ready is routed straight to the owner's in_ready; stray non-sop beats are sunk in IDLE.
module avalon_st_pkt_arbiter_10gb
    import avalon_st_10gb_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int IPG    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pause,
    input  logic [NPORTS*64-1:0]  in_data,
    input  logic [NPORTS-1:0]     in_valid,
    output logic [NPORTS-1:0]     in_ready,
    input  logic [NPORTS-1:0]     in_sop,
    input  logic [NPORTS-1:0]     in_eop,
    input  logic [NPORTS*3-1:0]   in_empty,
    input  logic [NPORTS*6-1:0]   in_error,
    output logic [63:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [2:0]            out_empty,
    output logic [5:0]            out_error,
    output logic [NPORTS-1:0]     grant,
    output logic                  busy,
    output logic [15:0]           pkt_count,
    output logic [15:0]           drop_count
);

    localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (IPG > 0) ? GAP_W'(IPG - 1) : '0;

    state_t             state_q, state_d;
    logic [NPORTS-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   pkt_q, pkt_d;
    logic [CNT_W-1:0]   drop_q, drop_d;

    logic [NPORTS-1:0]  eligible;
    logic [NPORTS-1:0]  stray;
    logic [NPORTS-1:0]  pick_sel;
    logic [IDX_W-1:0]   pick_idx;
    logic [NPORTS-1:0]  ready_c;
    logic               xfer_eop;

    assign eligible = in_valid & in_sop;
    assign stray    = in_valid & ~in_sop;

    rr_pick #(
        .NPORTS (NPORTS),
        .IDX_W  (IDX_W)
    ) u_rr_pick (
        .eligible (eligible),
        .last     (last_q),
        .sel      (pick_sel)
    );

    always_comb begin
        pick_idx = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (pick_sel[p]) pick_idx = IDX_W'(p);
        end
    end

    // grant_q is non-zero only in SEND, so the mux output is all-zero elsewhere.
    always_comb begin
        out_data  = '0;
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_empty = '0;
        out_error = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (grant_q[p]) begin
                out_data  = in_data[p*DATA_W +: DATA_W];
                out_valid = in_valid[p];
                out_sop   = in_sop[p];
                out_eop   = in_eop[p];
                out_empty = in_empty[p*EMPTY_W +: EMPTY_W];
                out_error = in_error[p*ERROR_W +: ERROR_W];
            end
        end
    end

    always_comb begin
        ready_c = '0;
        case (state_q)
            ST_IDLE: ready_c = stray;
            ST_SEND: ready_c = grant_q & {NPORTS{out_ready}};
            default: ready_c = '0;
        endcase
    end

    // Stray sinking is combinational, so hold it off while reset is asserted.
    assign in_ready = ready_c & {NPORTS{reset_n}};

    assign xfer_eop = out_valid & out_ready & out_eop;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        gap_d   = gap_q;
        pkt_d   = pkt_q;
        drop_d  = drop_q;
        case (state_q)
            ST_IDLE: begin
                if ((|stray) && (drop_q != {CNT_W{1'b1}})) drop_d = drop_q + 16'd1;
                if (!pause && (|eligible)) begin
                    grant_d = pick_sel;
                    last_d  = pick_idx;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer_eop) begin
                    pkt_d   = pkt_q + 16'd1;
                    grant_d = '0;
                    if (IPG > 0) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) state_d = ST_IDLE;
                else             gap_d   = gap_q - 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NPORTS - 1);
            gap_q   <= '0;
            pkt_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            pkt_q   <= pkt_d;
            drop_q  <= drop_d;
        end
    end

    assign grant      = grant_q;
    assign busy       = (state_q == ST_SEND) || (state_q == ST_GAP);
    assign pkt_count  = pkt_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_avalon_st_pkt_arbiter_10gb.sv
// Directed bench for the packet arbiter with NPORTS=2, IPG=4.
module tb_avalon_st_pkt_arbiter_10gb;

    logic          clk;
    logic          reset_n;
    logic          pause;
    logic [127:0]  in_data;
    logic [1:0]    in_valid;
    logic [1:0]    in_ready;
    logic [1:0]    in_sop;
    logic [1:0]    in_eop;
    logic [5:0]    in_empty;
    logic [11:0]   in_error;
    logic [63:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_sop;
    logic          out_eop;
    logic [2:0]    out_empty;
    logic [5:0]    out_error;
    logic [1:0]    grant;
    logic          busy;
    logic [15:0]   pkt_count;
    logic [15:0]   drop_count;

    int checks = 0;
    int errors = 0;

    avalon_st_pkt_arbiter_10gb #(.NPORTS(2), .IPG(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pause      (pause),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_empty   (in_empty),
        .in_error   (in_error),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_empty  (out_empty),
        .out_error  (out_error),
        .grant      (grant),
        .busy       (busy),
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] dat(input int p, input int k, input int b);
        return {48'hA5A5_0000_0000, 4'(p), 4'(k), 4'(b), 4'h0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic put(input int p, input logic v, input logic s, input logic e,
                       input logic [63:0] d, input logic [2:0] em = 3'd0, input logic [5:0] er = 6'd0);
        in_valid[p]         = v;
        in_sop[p]           = s;
        in_eop[p]           = e;
        in_data[p*64 +: 64] = d;
        in_empty[p*3 +: 3]  = em;
        in_error[p*6 +: 6]  = er;
    endtask

    task automatic clear_all();
        in_valid = '0;
        in_sop   = '0;
        in_eop   = '0;
        in_data  = '0;
        in_empty = '0;
        in_error = '0;
    endtask

    task automatic do_reset();
        clear_all();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        settle();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 50) begin
            tick();
            settle();
            n++;
        end
        check(tag, 64'(busy), 0);
    endtask

    initial begin
        int sent [2];
        int beat [2];
        int j;
        int b;

        reset_n   = 1'b0;
        pause     = 1'b0;
        out_ready = 1'b1;
        clear_all();

        // Reset: outputs zero even with a stray beat offered
        put(0, 1'b1, 1'b0, 1'b0, dat(0, 15, 0));
        #3;
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_grant", 64'(grant), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_pkt", 64'(pkt_count), 0);
        check("rst_drop", 64'(drop_count), 0);
        clear_all();
        tick();
        tick();
        reset_n = 1'b1;
        settle();

        // Single source: 3-beat packet then single-beat packet, IPG spacing
        put(0, 1'b1, 1'b1, 1'b0, dat(0, 0, 0));
        settle();
        check("A_arb_rdy", 64'(in_ready), 0);
        check("A_arb_ovld", 64'(out_valid), 0);
        tick();
        settle();
        check("A_grant", 64'(grant), 1);
        check("A_b0_sop", 64'(out_sop), 1);
        check("A_b0_dat", out_data, dat(0, 0, 0));
        check("A_b0_rdy", 64'(in_ready), 1);
        tick();
        put(0, 1'b1, 1'b0, 1'b0, dat(0, 0, 1));
        settle();
        check("A_b1_dat", out_data, dat(0, 0, 1));
        check("A_b1_sop", 64'(out_sop), 0);
        tick();
        put(0, 1'b1, 1'b0, 1'b1, dat(0, 0, 2), 3'd3);
        settle();
        check("A_b2_eop", 64'(out_eop), 1);
        check("A_b2_empty", 64'(out_empty), 3);
        tick();
        put(0, 1'b1, 1'b1, 1'b1, dat(0, 1, 0));
        settle();
        check("A_gap_grant", 64'(grant), 0);
        check("A_gap_busy", 64'(busy), 1);
        check("A_gap_rdy", 64'(in_ready), 0);
        check("A_pkt1", 64'(pkt_count), 1);
        for (int k = 2; k <= 5; k++) begin
            tick();
            settle();
            check("A_gap_ovld", 64'(out_valid), 0);
        end
        check("A_arb2_grant", 64'(grant), 0);
        tick();
        settle();
        check("A_p2_grant", 64'(grant), 1);
        check("A_p2_sop", 64'(out_sop), 1);
        check("A_p2_eop", 64'(out_eop), 1);
        tick();
        clear_all();
        settle();
        check("A_pkt2", 64'(pkt_count), 2);

        // Two sources, two 2-beat packets each: grants alternate 0,1,0,1
        do_reset();
        sent[0] = 0; sent[1] = 0; beat[0] = 0; beat[1] = 0;
        j = 0;
        for (int cyc = 0; cyc < 120 && j < 8; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (sent[p] < 2) put(p, 1'b1, beat[p] == 0, beat[p] == 1, dat(p, sent[p], beat[p]));
                else             put(p, 1'b0, 1'b0, 1'b0, 64'h0);
            end
            settle();
            if (out_valid && out_ready) begin
                check("B_dat", out_data, dat((j / 2) % 2, j / 4, j % 2));
                check("B_grant", 64'(grant), (j / 2) % 2 == 0 ? 1 : 2);
                check("B_other_rdy", 64'(in_ready & ~grant), 0);
                j++;
            end
            for (int p = 0; p < 2; p++) begin
                if (in_valid[p] && in_ready[p]) begin
                    if (beat[p] == 1) begin
                        beat[p] = 0;
                        sent[p]++;
                    end else begin
                        beat[p] = 1;
                    end
                end
            end
            tick();
        end
        clear_all();
        settle();
        check("B_beats", 64'(j), 8);
        check("B_pkt4", 64'(pkt_count), 4);
        wait_idle("B_idle");

        // Backpressure on port 1 with port 0 queued behind it
        put(1, 1'b1, 1'b1, 1'b0, dat(1, 2, 0));
        settle();
        check("C_arb_rdy", 64'(in_ready), 0);
        tick();
        put(0, 1'b1, 1'b1, 1'b0, dat(0, 9, 0));
        b = 0;
        for (int i = 0; i < 12 && b < 4; i++) begin
            out_ready = (i % 2 == 0);
            put(1, 1'b1, b == 0, b == 3, dat(1, 2, b));
            settle();
            check("C_rdy1", 64'(in_ready[1]), (i % 2 == 0) ? 1 : 0);
            check("C_rdy0", 64'(in_ready[0]), 0);
            check("C_dat", out_data, dat(1, 2, b));
            check("C_eop", 64'(out_eop), (b == 3) ? 1 : 0);
            if (i % 2 == 0) b++;
            tick();
        end
        clear_all();
        out_ready = 1'b1;
        settle();
        check("C_beats", 64'(b), 4);
        check("C_pkt5", 64'(pkt_count), 5);
        wait_idle("C_idle");

        // Stray beats in IDLE are sunk and counted
        put(0, 1'b1, 1'b0, 1'b0, dat(0, 7, 0));
        settle();
        check("D_rdy", 64'(in_ready), 1);
        check("D_ovld", 64'(out_valid), 0);
        tick();
        settle();
        check("D_drop1", 64'(drop_count), 1);
        tick();
        clear_all();
        settle();
        check("D_drop2", 64'(drop_count), 2);
        check("D_busy", 64'(busy), 0);

        // Pause blocks grants (not drops); pause mid-packet is ignored
        pause = 1'b1;
        put(1, 1'b1, 1'b1, 1'b0, dat(1, 3, 0));
        put(0, 1'b1, 1'b0, 1'b0, dat(0, 8, 0));
        settle();
        check("E_stray_rdy", 64'(in_ready), 1);
        tick();
        put(0, 1'b0, 1'b0, 1'b0, 64'h0);
        settle();
        check("E_pause_grant", 64'(grant), 0);
        check("E_drop3", 64'(drop_count), 3);
        check("E_pause_rdy", 64'(in_ready), 0);
        tick();
        settle();
        check("E_pause_busy", 64'(busy), 0);
        pause = 1'b0;
        tick();
        settle();
        check("E_grant", 64'(grant), 2);
        check("E_sop", 64'(out_sop), 1);
        pause = 1'b1;
        tick();
        put(1, 1'b1, 1'b0, 1'b1, dat(1, 3, 1), 3'd5, 6'h2A);
        settle();
        check("E_mid_grant", 64'(grant), 2);
        check("E_mid_ovld", 64'(out_valid), 1);
        check("E_mid_err", 64'(out_error), 64'h2A);
        check("E_mid_empty", 64'(out_empty), 5);
        tick();
        clear_all();
        pause = 1'b0;
        settle();
        check("E_pkt6", 64'(pkt_count), 6);
        wait_idle("E_idle");

        // Reset mid-packet: leftovers become strays, next sop is granted
        put(0, 1'b1, 1'b1, 1'b0, dat(0, 4, 0));
        settle();
        tick();
        settle();
        check("F_grant", 64'(grant), 1);
        tick();
        put(0, 1'b1, 1'b0, 1'b0, dat(0, 4, 1));
        settle();
        check("F_pre_ovld", 64'(out_valid), 1);
        reset_n = 1'b0;
        #1;
        check("F_rst_ovld", 64'(out_valid), 0);
        check("F_rst_grant", 64'(grant), 0);
        check("F_rst_pkt", 64'(pkt_count), 0);
        check("F_rst_drop", 64'(drop_count), 0);
        check("F_rst_rdy", 64'(in_ready), 0);
        tick();
        reset_n = 1'b1;
        settle();
        check("F_stray_rdy", 64'(in_ready), 1);
        check("F_stray_ovld", 64'(out_valid), 0);
        tick();
        put(0, 1'b1, 1'b0, 1'b1, dat(0, 4, 2));
        settle();
        check("F_drop1", 64'(drop_count), 1);
        tick();
        put(0, 1'b1, 1'b1, 1'b1, dat(0, 5, 0));
        settle();
        check("F_drop2", 64'(drop_count), 2);
        check("F_arb_rdy", 64'(in_ready), 0);
        tick();
        settle();
        check("F_new_grant", 64'(grant), 1);
        check("F_new_dat", out_data, dat(0, 5, 0));
        tick();
        clear_all();
        settle();
        check("F_pkt1", 64'(pkt_count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
